// File: rtl/rsi_pkg.sv
// Shared definitions for the RSI price feeder: default widths, the RSI_FSM
// tick latency the pulse spacing is derived from, and feeder state encodings.
package rsi_pkg;

    // Price width of RSI_FSM price_in
    localparam int PRICE_W_DEF    = 50;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int CNT_W_DEF      = 16;

    // RSI_FSM needs about this many cycles per tick (IDLE->FETCH->COMPUTE->
    // WAIT_DIV->DECISION); the default gap adds two cycles of margin.
    localparam int RSI_TICK_LATENCY = 14;
    localparam int MIN_GAP_DEF      = RSI_TICK_LATENCY + 2;

    // Feeder state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_EOD   = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        ISSUE  = ST_ISSUE,
        EOD_ST = ST_EOD,
        GAP    = ST_GAP
    } feeder_state_e;

endpackage

// File: rtl/rsi_price_feeder_if.sv
// Upstream side of the feeder: tick price with valid/ready plus the
// end-of-day request.
//
// Handshake: a tick transfers on every rising clk edge where s_valid and
// s_ready are both 1. The source holds s_price stable while s_valid is high
// and s_ready is low. s_ready depends only on feeder registers, never on
// s_valid. eod_req is a single-cycle request with no ready; it is ignored
// while an end-of-day is already pending.
interface rsi_price_feeder_if #(
    parameter int PRICE_W = rsi_pkg::PRICE_W_DEF
);
    logic [PRICE_W-1:0] s_price;
    logic               s_valid;
    logic               s_ready;
    logic               eod_req;

    // Market-data source side
    modport master (
        output s_price,
        output s_valid,
        output eod_req,
        input  s_ready
    );

    // Feeder side
    modport slave (
        input  s_price,
        input  s_valid,
        input  eod_req,
        output s_ready
    );
endinterface

// File: rtl/tick_fifo.sv
// Synchronous first-word-fall-through FIFO holding queued price ticks.
// Push into a full FIFO and pop from an empty one are ignored.
module tick_fifo #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign level   = count;

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/rsi_price_feeder.sv
// Transmit side of the RSI_FSM price-tick interface. Buffers upstream ticks,
// issues one new_price pulse per tick no closer than MIN_GAP+1 cycles apart,
// and issues the EOD pulse after every tick queued ahead of it.
module rsi_price_feeder
    import rsi_pkg::*;
#(
    parameter int PRICE_W    = PRICE_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int MIN_GAP    = MIN_GAP_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    rsi_price_feeder_if.slave             up,
    output logic [PRICE_W-1:0]            price_out,
    output logic                          new_price,
    output logic                          EOD,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]              tick_count,
    output logic                          busy,
    output feeder_state_e                 state_dbg
);
    // Gap counter only has to hold MIN_GAP-1
    localparam int GW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(MIN_GAP - 1);

    feeder_state_e     state;
    feeder_state_e     state_next;
    logic [GW-1:0]     gap_cnt;
    logic [GW-1:0]     gap_next;
    logic              eod_pending;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PRICE_W-1:0] fifo_head;

    // Ready depends only on registered state; holding off ticks while an
    // EOD is pending keeps the EOD behind everything accepted before it.
    assign up.s_ready = !fifo_full && !eod_pending;
    assign fifo_push  = up.s_valid && up.s_ready;
    assign busy       = (state != IDLE) || !fifo_empty || eod_pending;
    assign state_dbg  = state;

    tick_fifo #(
        .WIDTH (PRICE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (up.s_price),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Next-state, gap counter and pop decision; ticks beat a pending EOD
    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        fifo_pop   = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = ISSUE;
                    fifo_pop   = 1'b1;
                end else if (eod_pending) begin
                    state_next = EOD_ST;
                end
            end
            ISSUE, EOD_ST: begin
                if (MIN_GAP == 1) begin
                    state_next = IDLE;
                end else begin
                    state_next = GAP;
                    gap_next   = GAP_LOAD;
                end
            end
            GAP: begin
                gap_next = gap_cnt - GW'(1);
                // IDLE decides the next pulse one cycle after leaving GAP
                if (gap_cnt <= GW'(1)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and registered pulse/price outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            new_price <= 1'b0;
            EOD       <= 1'b0;
            price_out <= '0;
        end else begin
            state     <= state_next;
            gap_cnt   <= gap_next;
            new_price <= fifo_pop;
            EOD       <= (state == IDLE) && (state_next == EOD_ST);
            if (fifo_pop) price_out <= fifo_head;
        end
    end

    // End-of-day pending flag and per-day tick counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            eod_pending <= 1'b0;
            tick_count  <= '0;
        end else begin
            if (state == EOD_ST) begin
                eod_pending <= 1'b0;
                tick_count  <= '0;
            end else begin
                if (up.eod_req) eod_pending <= 1'b1;
                if (state == ISSUE && tick_count != {CNT_W{1'b1}})
                    tick_count <= tick_count + CNT_W'(1);
            end
        end
    end

endmodule
